// File: rtl/dmem_init_ctrl.sv
// Data-memory init/readback controller. In IDLE the CPU MEM-stage request
// passes straight through to the data memory. A host can instead stream words
// into memory (load, written as pairs where possible) or read them back (dump).
module dmem_init_ctrl (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        start_load,
    input  logic        start_dump,
    input  logic [11:0] base_addr,
    input  logic [10:0] word_count,
    input  logic [31:0] host_wdata,
    input  logic        host_wvalid,
    output logic        host_wready,
    output logic [31:0] host_rdata,
    output logic        host_rvalid,
    input  logic        host_rready,
    input  logic [11:0] cpu_address,
    input  logic [31:0] cpu_datain,
    input  logic [3:0]  cpu_wr,
    input  logic        cpu_halt,
    output logic [11:0] mem_address,
    output logic [31:0] mem_datain1,
    output logic [31:0] mem_datain2,
    output logic [3:0]  mem_wr,
    output logic        mem_load_pair,
    output logic        mem_halt,
    input  logic [31:0] mem_dataout,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        StIdle, StLGet0, StLGet1, StLWrite, StDAddr, StDWait, StDOut, StFinish
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] cur_addr_q, cur_addr_d;
    logic [10:0] remaining_q, remaining_d;
    logic [31:0] word0_q, word0_d;
    logic [31:0] word1_q, word1_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // End address computed wide so an out-of-range request cannot wrap to look legal.
    logic [13:0] end_addr;
    logic        start_err;
    logic        pair;
    logic [10:0] write_rem;

    assign end_addr  = {2'b00, base_addr} + {1'b0, word_count, 2'b00};
    assign start_err = (base_addr[1:0] != 2'b00) || (end_addr > 14'd4096);
    // Pair decision is taken from the count still outstanding at the write.
    assign pair      = remaining_q > 11'd1;
    assign write_rem = pair ? (remaining_q - 11'd2) : (remaining_q - 11'd1);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= StIdle;
            cur_addr_q  <= 12'h000;
            remaining_q <= 11'd0;
            word0_q     <= 32'h0;
            word1_q     <= 32'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            word0_q     <= word0_d;
            word1_q     <= word1_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Next-state, datapath updates and all outputs.
    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        remaining_d   = remaining_q;
        word0_d       = word0_q;
        word1_d       = word1_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        mem_address   = cur_addr_q;
        mem_datain1   = 32'h0;
        mem_datain2   = 32'h0;
        mem_wr        = 4'h0;
        mem_load_pair = 1'b0;
        mem_halt      = 1'b0;
        host_wready   = 1'b0;
        host_rvalid   = 1'b0;
        host_rdata    = rdata_q;
        busy          = 1'b1;
        done          = 1'b0;
        error         = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy        = 1'b0;
                mem_address = cpu_address;
                mem_datain1 = cpu_datain;
                mem_wr      = cpu_wr;
                mem_halt    = cpu_halt;
                // Load wins when both starts arrive together.
                if (start_load || start_dump) begin
                    cur_addr_d  = base_addr;
                    remaining_d = word_count;
                    err_d       = start_err;
                    if (start_err || (word_count == 11'd0)) begin
                        state_d = StFinish;
                    end else if (start_load) begin
                        state_d = StLGet0;
                    end else begin
                        state_d = StDAddr;
                    end
                end
            end
            StLGet0: begin
                host_wready = 1'b1;
                if (host_wvalid) begin
                    word0_d = host_wdata;
                    state_d = pair ? StLGet1 : StLWrite;
                end
            end
            StLGet1: begin
                host_wready = 1'b1;
                if (host_wvalid) begin
                    word1_d = host_wdata;
                    state_d = StLWrite;
                end
            end
            StLWrite: begin
                mem_wr      = 4'hF;
                mem_datain1 = word0_q;
                if (pair) begin
                    mem_datain2   = word1_q;
                    mem_load_pair = 1'b1;
                    cur_addr_d    = cur_addr_q + 12'd8;
                end else begin
                    cur_addr_d    = cur_addr_q + 12'd4;
                end
                remaining_d = write_rem;
                state_d     = (write_rem != 11'd0) ? StLGet0 : StFinish;
            end
            StDAddr: begin
                state_d = StDWait;
            end
            StDWait: begin
                rdata_d = mem_dataout;
                state_d = StDOut;
            end
            StDOut: begin
                host_rvalid = 1'b1;
                if (host_rready) begin
                    cur_addr_d  = cur_addr_q + 12'd4;
                    remaining_d = remaining_q - 11'd1;
                    state_d     = (remaining_q != 11'd1) ? StDAddr : StFinish;
                end
            end
            StFinish: begin
                done    = 1'b1;
                error   = err_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Reset cycle: nothing reaches the memory or the host regardless of state.
        if (Rst) begin
            mem_wr        = 4'h0;
            mem_halt      = 1'b0;
            mem_load_pair = 1'b0;
            mem_datain2   = 32'h0;
            host_wready   = 1'b0;
            host_rvalid   = 1'b0;
            host_rdata    = 32'h0;
            busy          = 1'b0;
            done          = 1'b0;
            error         = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_init_ctrl.sv
// Bench for dmem_init_ctrl: behavioural data memory plus write/read scoreboards.
module tb_dmem_init_ctrl;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        start_load, start_dump;
    logic [11:0] base_addr;
    logic [10:0] word_count;
    logic [31:0] host_wdata;
    logic        host_wvalid, host_wready;
    logic [31:0] host_rdata;
    logic        host_rvalid, host_rready;
    logic [11:0] cpu_address;
    logic [31:0] cpu_datain;
    logic [3:0]  cpu_wr;
    logic        cpu_halt;
    logic [11:0] mem_address;
    logic [31:0] mem_datain1, mem_datain2;
    logic [3:0]  mem_wr;
    logic        mem_load_pair, mem_halt;
    logic [31:0] mem_dataout;
    logic        busy, done, error;

    always #5 Clk = ~Clk;

    dmem_init_ctrl dut (
        .Clk(Clk), .Rst(Rst), .start_load(start_load), .start_dump(start_dump),
        .base_addr(base_addr), .word_count(word_count),
        .host_wdata(host_wdata), .host_wvalid(host_wvalid), .host_wready(host_wready),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_rready(host_rready),
        .cpu_address(cpu_address), .cpu_datain(cpu_datain), .cpu_wr(cpu_wr),
        .cpu_halt(cpu_halt), .mem_address(mem_address), .mem_datain1(mem_datain1),
        .mem_datain2(mem_datain2), .mem_wr(mem_wr), .mem_load_pair(mem_load_pair),
        .mem_halt(mem_halt), .mem_dataout(mem_dataout),
        .busy(busy), .done(done), .error(error)
    );

    // Data memory model: byte-enabled writes, dual-word init write, 1-cycle read.
    logic [31:0] mem [0:1023];
    logic [9:0]  widx, widx1;
    assign widx  = mem_address[11:2];
    assign widx1 = widx + 10'd1;

    always @(posedge Clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_wr[b]) begin
                mem[widx][8*b +: 8] <= mem_datain1[8*b +: 8];
                if (mem_load_pair) mem[widx1][8*b +: 8] <= mem_datain2[8*b +: 8];
            end
        end
        mem_dataout <= mem[widx];
    end

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        pair;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [31:0] host_words[$];
    int          checks = 0;
    int          failures = 0;

    localparam logic [31:0] WA = 32'h1111_AAAA, WB = 32'h2222_BBBB;
    localparam logic [31:0] WC = 32'h3333_CCCC, WD = 32'h4444_DDDD;

    // Runs one operation cycle by cycle, scoreboarding writes and readback beats.
    task automatic run_op(input logic ld, input logic dp, input logic [11:0] base,
                          input logic [10:0] cnt, input int stall, input logic exp_err,
                          input int dump_pulse_at, output int ndone);
        logic        hs_w, prev_valid, prev_hs_r, saw_done, finished;
        logic [31:0] prev_rdata, er;
        wr_t         e;
        int          stall_left;
        ndone = 0; stall_left = stall; prev_valid = 0; prev_hs_r = 0;
        saw_done = 0; finished = 0; prev_rdata = 0;
        start_load = ld; start_dump = dp; base_addr = base; word_count = cnt;
        host_wvalid = host_words.size() > 0;
        host_wdata  = host_wvalid ? host_words[0] : 32'h0;
        @(posedge Clk); #1;
        start_load = 0; start_dump = 0;
        // Hostile CPU request that must be ignored while busy.
        cpu_wr = 4'hF; cpu_halt = 1; cpu_address = 12'hABC; cpu_datain = 32'hDEAD_BEEF;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            @(negedge Clk);
            if (mem_wr !== 4'h0) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write addr=%h wr=%h", mem_address, mem_wr);
                end else begin
                    e = exp_wr.pop_front();
                    if ({mem_address, mem_datain1, mem_datain2, mem_load_pair} !== e ||
                        mem_wr !== 4'hF) begin
                        failures++;
                        $display("FAIL write got=%h/%h/%h/%b wr=%h exp=%h/%h/%h/%b wr=f",
                                 mem_address, mem_datain1, mem_datain2, mem_load_pair,
                                 mem_wr, e.addr, e.d1, e.d2, e.pair);
                    end
                end
            end
            if (busy === 1'b1) begin
                checks++;
                if (mem_halt !== 1'b0) begin
                    failures++;
                    $display("FAIL halt_while_busy got=%b exp=0", mem_halt);
                end
            end
            if (host_rvalid === 1'b1) begin
                if (prev_valid && !prev_hs_r) begin
                    checks++;
                    if (host_rdata !== prev_rdata) begin
                        failures++;
                        $display("FAIL rdata_stable got=%h exp=%h", host_rdata, prev_rdata);
                    end
                end
                prev_rdata = host_rdata; prev_valid = 1;
                if (stall_left > 0) begin
                    stall_left--; host_rready = 0; prev_hs_r = 0;
                end else begin
                    host_rready = 1; prev_hs_r = 1; checks++;
                    if (exp_rd.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_read got=%h", host_rdata);
                    end else begin
                        er = exp_rd.pop_front();
                        if (host_rdata !== er) begin
                            failures++;
                            $display("FAIL readback got=%h exp=%h", host_rdata, er);
                        end
                    end
                end
            end else begin
                host_rready = 0; prev_valid = 0; prev_hs_r = 0;
            end
            hs_w = host_wready & host_wvalid;
            if (done === 1'b1) begin
                ndone++; saw_done = 1; checks++;
                if (error !== exp_err) begin
                    failures++;
                    $display("FAIL error_flag got=%b exp=%b", error, exp_err);
                end
                cpu_wr = 4'h0; cpu_halt = 0;
            end else if (saw_done) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_after_done busy got=%b exp=0", busy);
                end
                finished = 1;
            end
            if (cyc == dump_pulse_at) start_dump = 1;
            @(posedge Clk); #1;
            start_dump = 0;
            if (hs_w) begin
                void'(host_words.pop_front());
                host_wvalid = host_words.size() > 0;
                host_wdata  = host_wvalid ? host_words[0] : 32'h0;
            end
        end
        if (!finished) begin
            checks++; failures++;
            $display("FAIL timeout done_seen=%0d exp=1", ndone);
        end
        checks++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
            failures++;
            $display("FAIL leftover writes=%0d reads=%0d exp=0/0", exp_wr.size(), exp_rd.size());
        end
        exp_wr.delete(); exp_rd.delete(); host_words.delete();
        host_rready = 0; host_wvalid = 0; cpu_wr = 0; cpu_halt = 0;
    endtask

    task automatic test_reset();
        Rst = 1; cpu_wr = 4'hF; cpu_halt = 1; cpu_address = 12'h7F0; cpu_datain = 32'h5A5A_0001;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({busy, done, error, host_wready, host_rvalid, mem_load_pair, mem_wr, mem_halt} !== 0 ||
            host_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b%b%b%b%b %h %b rdata=%h exp=all zero",
                     busy, done, error, host_wready, host_rvalid, mem_load_pair, mem_wr,
                     mem_halt, host_rdata);
        end
        Rst = 0; cpu_wr = 4'h5; #1;
        checks++;
        if ({mem_address, mem_datain1, mem_wr, mem_halt} !== {12'h7F0, 32'h5A5A_0001, 4'h5, 1'b1}
            || mem_datain2 !== 32'h0 || mem_load_pair !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_passthrough got=%h/%h/%h/%b exp=7f0/5a5a0001/5/1",
                     mem_address, mem_datain1, mem_wr, mem_halt);
        end
        @(posedge Clk); #1;
        cpu_wr = 0; cpu_halt = 0;
    endtask

    task automatic test_load_pairs();
        int nd;
        host_words = '{WA, WB, WC, WD};
        exp_wr.push_back('{12'h010, WA, WB, 1'b1});
        exp_wr.push_back('{12'h018, WC, WD, 1'b1});
        run_op(1, 0, 12'h010, 11'd4, 0, 0, -1, nd);
        checks++;
        if (nd != 1) begin failures++; $display("FAIL load_pairs_done got=%0d exp=1", nd); end
    endtask

    task automatic test_load_odd();
        int nd;
        host_words = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222};
        exp_wr.push_back('{12'h000, 32'hA0A0_0000, 32'hA1A1_1111, 1'b1});
        exp_wr.push_back('{12'h008, 32'hA2A2_2222, 32'h0, 1'b0});
        run_op(1, 0, 12'h000, 11'd3, 0, 0, -1, nd);
        checks++;
        if (nd != 1) begin failures++; $display("FAIL load_odd_done got=%0d exp=1", nd); end
    endtask

    task automatic test_dump();
        int nd;
        exp_rd.push_back(WA);
        exp_rd.push_back(WB);
        run_op(0, 1, 12'h010, 11'd2, 3, 0, -1, nd);
        checks++;
        if (nd != 1) begin failures++; $display("FAIL dump_done got=%0d exp=1", nd); end
    endtask

    task automatic test_errors();
        int nd;
        run_op(1, 0, 12'h002, 11'd1, 0, 1, -1, nd);
        checks++;
        if (nd != 1) begin failures++; $display("FAIL misaligned_done got=%0d exp=1", nd); end
        host_words = '{WA, WB};
        run_op(1, 0, 12'hFFC, 11'd2, 0, 1, -1, nd);
        checks++;
        if (nd != 1) begin failures++; $display("FAIL overflow_done got=%0d exp=1", nd); end
        run_op(1, 0, 12'h100, 11'd0, 0, 0, -1, nd);
        checks++;
        if (nd != 1) begin failures++; $display("FAIL zero_count_done got=%0d exp=1", nd); end
    endtask

    task automatic test_boundary();
        int nd;
        host_words = '{32'hB0B0_0001, 32'hB1B1_0002};
        exp_wr.push_back('{12'hFF8, 32'hB0B0_0001, 32'hB1B1_0002, 1'b1});
        run_op(1, 0, 12'hFF8, 11'd2, 0, 0, -1, nd);
        host_words = '{32'hC0C0_0003};
        exp_wr.push_back('{12'hFFC, 32'hC0C0_0003, 32'h0, 1'b0});
        run_op(1, 0, 12'hFFC, 11'd1, 0, 0, -1, nd);
        checks++;
        if (nd != 1) begin failures++; $display("FAIL top_single_done got=%0d exp=1", nd); end
    endtask

    task automatic test_back_to_back();
        int nd;
        host_words = '{32'hE0E0_0E0E, 32'hF0F0_0F0F};
        exp_wr.push_back('{12'h020, 32'hE0E0_0E0E, 32'hF0F0_0F0F, 1'b1});
        run_op(1, 1, 12'h020, 11'd2, 0, 0, 1, nd);
        checks++;
        if (nd != 1) begin failures++; $display("FAIL both_start_done got=%0d exp=1", nd); end
    endtask

    task automatic test_rst_mid();
        start_load = 1; base_addr = 12'h040; word_count = 11'd4;
        host_wvalid = 1; host_wdata = 32'h7777_0001;
        @(posedge Clk); #1;
        start_load = 0;
        @(posedge Clk); #1;
        host_wvalid = 0;
        checks++;
        if (host_wready !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL in_lget1 wready=%b busy=%b exp=1/1", host_wready, busy);
        end
        Rst = 1; cpu_wr = 4'hF; cpu_halt = 1; cpu_address = 12'h7F0; #1;
        checks++;
        if (mem_wr !== 4'h0 || mem_halt !== 1'b0 || busy !== 1'b0 || host_wready !== 1'b0) begin
            failures++;
            $display("FAIL rst_cycle wr=%h halt=%b busy=%b wready=%b exp=0/0/0/0",
                     mem_wr, mem_halt, busy, host_wready);
        end
        @(posedge Clk); #1;
        Rst = 0; cpu_wr = 4'h3; cpu_halt = 0; #1;
        checks++;
        if (busy !== 1'b0 || mem_wr !== 4'h3 || mem_address !== 12'h7F0) begin
            failures++;
            $display("FAIL after_rst busy=%b wr=%h addr=%h exp=0/3/7f0", busy, mem_wr, mem_address);
        end
        @(posedge Clk); #1;
        cpu_wr = 0;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL stays_idle busy=%b exp=0", busy); end
    endtask

    initial begin
        Rst = 1; start_load = 0; start_dump = 0; base_addr = 0; word_count = 0;
        host_wdata = 0; host_wvalid = 0; host_rready = 0;
        cpu_address = 0; cpu_datain = 0; cpu_wr = 0; cpu_halt = 0;
        test_reset();
        test_load_pairs();
        test_load_odd();
        test_dump();
        test_errors();
        test_boundary();
        test_back_to_back();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_init_ctrl.md
DMEM_INIT_CTRL -- requirements
Module: dmem_init_ctrl

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- Clk  in  1  single clock; all state changes on rising edge.
- Rst  in  1  synchronous, active-high reset.
- start_load  in  1  one-cycle pulse; begin host-to-memory load.
- start_dump  in  1  one-cycle pulse; begin memory-to-host readback.
- base_addr  in  12  byte start address, sampled on accepted start.
- word_count  in  11  number of 32-bit words, 0..1024, sampled on accepted start.
- host_wdata / host_wvalid / host_wready  in/in/out  32/1/1  load stream; beat transfers when valid&ready.
- host_rdata / host_rvalid / host_rready  out/out/in  32/1/1  dump stream; beat transfers when valid&ready.
- cpu_address / cpu_datain / cpu_wr / cpu_halt  in  12/32/4/1  pipeline MEM-stage request (cpu_wr is active-high byte enables).
- mem_address / mem_datain1 / mem_datain2  out  12/32/32  data-memory address and write data (datain2 = second word of a pair).
- mem_wr  out  4  active-high byte write enables to the data memory.
- mem_load_pair  out  1  drives the memory's dual-write init mode.
- mem_halt  out  1  drives the memory's clock-gate halt.
- mem_dataout  in  32  data-memory read data, valid 1 cycle after address.
- busy / done / error  out  1/1/1  status.

Function
REQ-002 SHALL implement states IDLE, L_GET0, L_GET1, L_WRITE, D_ADDR, D_WAIT, D_OUT, FINISH.
REQ-003 In IDLE, SHALL pass cpu_address, cpu_datain, cpu_wr, cpu_halt through to mem_address, mem_datain1, mem_wr, mem_halt; mem_load_pair=0; mem_datain2=0.
REQ-004 In every non-IDLE state, SHALL drive mem_halt=0 and SHALL ignore all cpu_* inputs.
REQ-005 A start SHALL be accepted only in IDLE; starts in other states SHALL be dropped.
REQ-006 Simultaneous start_load and start_dump SHALL accept load only.
REQ-007 On an accepted start, if base_addr[1:0]!=0 or base_addr + 4*word_count > 4096, SHALL go to FINISH with error=1 and perform no memory write.
REQ-008 On an accepted start with word_count=0, SHALL go directly to FINISH with error=0.
REQ-009 Load: L_GET0 SHALL assert host_wready and capture word0 on handshake. Then:
- if remaining count >1, go to L_GET1;
- otherwise go to L_WRITE as a single write.
REQ-010 L_GET1 SHALL assert host_wready, capture word1 on handshake, then go to L_WRITE.
REQ-011 L_WRITE SHALL last exactly one cycle with host_wready=0. Outputs:
- pair: mem_address=cur_addr, mem_datain1=word0, mem_datain2=word1, mem_wr=4'hF, mem_load_pair=1; then cur_addr+=8, remaining-=2.
- single: mem_load_pair=0, mem_datain2=0; then cur_addr+=4, remaining-=1.
REQ-012 After L_WRITE, SHALL go to L_GET0 if remaining>0, else FINISH.
REQ-013 Dump: D_ADDR SHALL drive mem_address=cur_addr with mem_wr=0 for one cycle, then go to D_WAIT.
REQ-014 D_WAIT SHALL register mem_dataout into host_rdata, then go to D_OUT.
REQ-015 D_OUT SHALL hold host_rvalid=1 with host_rdata stable until host_rready. On handshake: cur_addr+=4, remaining-=1; next state D_ADDR if remaining>0, else FINISH.
REQ-016 Outside D_OUT, host_rvalid SHALL be 0; outside L_GET0/L_GET1, host_wready SHALL be 0.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 FINISH SHALL pulse done=1 for exactly one cycle, hold error for that cycle, then return to IDLE.
REQ-019 Address arithmetic SHALL be 12-bit; a wrap cannot occur once REQ-007 passes. The remaining counter SHALL be 11-bit.

Reset
REQ-020 Rst=1 SHALL force IDLE, busy=done=error=0, host_wready=host_rvalid=0, host_rdata=0, mem_load_pair=0, internal counters and registers 0.
REQ-021 Rst asserted mid-operation SHALL abort the operation with no memory write in the reset cycle (mem_wr=0, mem_halt=0). The IDLE passthrough SHALL resume on the first cycle after Rst deasserts.

Verification
REQ-022 Load base=0x010, count=4, host words A,B,C,D -> two pair writes: (0x010, A, B) then (0x018, C, D), each with mem_load_pair=1; then one done pulse, error=0.
REQ-023 Load base=0x000, count=3 -> pair write (0x000, W0, W1), then single write at 0x008 with mem_load_pair=0 and mem_wr=4'hF.
REQ-024 Dump base=0x010, count=2 with host_rready held 0 for 3 cycles -> host_rvalid/host_rdata stable throughout; readback equals A then B.
REQ-025 start_load base=0x002 -> error=1 and done pulse; no cycle with mem_wr!=0. Same result for base=0xFFC, count=2.
REQ-026 start_load and start_dump in the same cycle -> load performed; a start_dump during busy is ignored.
REQ-027 Rst during L_GET1 -> next cycle IDLE, busy=0; cpu_wr=4'h3 is passed to mem_wr immediately after reset deasserts.
